// File: rtl/gth_link_sequencer_pkg.sv
// Shared definitions for the SFP0 GTH link sequencer: state codes, status bit
// positions and the per-stage "required status" masks.
package gth_link_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RESET    = 3'd1,
        ST_WAIT_PLL = 3'd2,
        ST_WAIT_TX  = 3'd3,
        ST_WAIT_RX  = 3'd4,
        ST_UP       = 3'd5,
        ST_BACKOFF  = 3'd6,
        ST_FAILED   = 3'd7
    } gth_state_e;

    localparam int GS_PLL    = 0;
    localparam int GS_TXDONE = 1;
    localparam int GS_RXDONE = 2;
    localparam int GS_CDR    = 3;

    localparam logic [3:0] MASK_PLL = 4'b0001;
    localparam logic [3:0] MASK_TX  = 4'b0011;
    localparam logic [3:0] MASK_ALL = 4'b1111;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/gth_link_sequencer_sync.sv
// Parameterised-width two-flop synchronizer for the asynchronous GTH status bits.
module gth_link_sequencer_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta;
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

// File: rtl/gth_link_sequencer.sv
// Bring-up / recovery sequencer for the SFP0 GTH link: drives gth_rst, watches the
// synchronized status, times out, backs off and retries, and reports link state.
module gth_link_sequencer
    import gth_link_sequencer_pkg::*;
#(
    parameter int RST_CYCLES     = 256,
    parameter int TIMEOUT_CYCLES = 250000,
    parameter int DEBOUNCE       = 16,
    parameter int MAX_RETRY      = 7,
    parameter int BACKOFF_CYCLES = 1024
) (
    input  logic        axi_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        restart,
    input  logic [3:0]  gth_status,
    output logic        gth_rst,
    output logic        link_up,
    output logic        failed,
    output logic [2:0]  state,
    output logic [2:0]  retry_cnt,
    output logic [15:0] drop_cnt
);

    localparam int TMR_MAX = max3(RST_CYCLES, TIMEOUT_CYCLES, BACKOFF_CYCLES);
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam int DW      = $clog2(DEBOUNCE + 1);

    logic [3:0]    s;
    gth_state_e    st_q, st_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [2:0]    retry_d;
    logic [15:0]   drop_d;
    logic          timeout, attempt_fail;

    gth_link_sequencer_sync #(.WIDTH(4)) u_sync (
        .clk (axi_clk),
        .rst (rst),
        .d   (gth_status),
        .q   (s)
    );

    assign timeout = (tmr_q == TW'(TIMEOUT_CYCLES - 1));

    // One shared timer serves RESET, every WAIT_* and BACKOFF; it is zeroed on
    // every state change so it never runs past the limit of the state it times.
    always_comb begin
        st_d         = st_q;
        tmr_d        = '0;
        deb_d        = '0;
        retry_d      = retry_cnt;
        drop_d       = drop_cnt;
        attempt_fail = 1'b0;
        if (!enable) begin
            st_d = ST_IDLE;
        end else if (restart) begin
            st_d    = ST_RESET;
            retry_d = '0;
        end else begin
            unique case (st_q)
                ST_IDLE: begin
                    st_d    = ST_RESET;
                    retry_d = '0;
                end
                ST_RESET: begin
                    if (tmr_q == TW'(RST_CYCLES - 1)) st_d = ST_WAIT_PLL;
                    else                              tmr_d = tmr_q + 1'b1;
                end
                ST_WAIT_PLL: begin
                    if (s[GS_PLL])     st_d = ST_WAIT_TX;
                    else if (timeout)  attempt_fail = 1'b1;
                    else               tmr_d = tmr_q + 1'b1;
                end
                ST_WAIT_TX: begin
                    if ((s & MASK_TX) == MASK_TX)              st_d = ST_WAIT_RX;
                    else if (!s[GS_PLL] || timeout)            attempt_fail = 1'b1;
                    else                                       tmr_d = tmr_q + 1'b1;
                end
                ST_WAIT_RX: begin
                    if (s == MASK_ALL)                         st_d = ST_UP;
                    else if ((s & MASK_TX) != MASK_TX || timeout) attempt_fail = 1'b1;
                    else                                       tmr_d = tmr_q + 1'b1;
                end
                ST_UP: begin
                    if (s != MASK_ALL) begin
                        if (deb_q == DW'(DEBOUNCE - 1)) begin
                            st_d    = ST_BACKOFF;
                            retry_d = '0;
                            drop_d  = (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
                        end else begin
                            deb_d = deb_q + 1'b1;
                        end
                    end
                end
                ST_BACKOFF: begin
                    if (tmr_q == TW'(BACKOFF_CYCLES - 1)) st_d = ST_RESET;
                    else                                  tmr_d = tmr_q + 1'b1;
                end
                ST_FAILED: ;
                default: st_d = ST_IDLE;
            endcase
            if (attempt_fail) begin
                if (retry_cnt < 3'(MAX_RETRY)) begin
                    retry_d = retry_cnt + 3'd1;
                    st_d    = ST_BACKOFF;
                end else begin
                    st_d = ST_FAILED;
                end
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (rst) begin
            st_q      <= ST_IDLE;
            tmr_q     <= '0;
            deb_q     <= '0;
            retry_cnt <= '0;
            drop_cnt  <= '0;
            gth_rst   <= 1'b1;
            link_up   <= 1'b0;
            failed    <= 1'b0;
        end else begin
            st_q      <= st_d;
            tmr_q     <= tmr_d;
            deb_q     <= deb_d;
            retry_cnt <= retry_d;
            drop_cnt  <= drop_d;
            gth_rst   <= !(st_d inside {ST_WAIT_PLL, ST_WAIT_TX, ST_WAIT_RX, ST_UP});
            link_up   <= (st_d == ST_UP);
            failed    <= (st_d == ST_FAILED);
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_gth_link_sequencer.sv
// Randomized bench for gth_link_sequencer: a reactive link model drives status and
// a dwell-time reference model predicts every output each cycle.
module tb_gth_link_sequencer;
    import gth_link_sequencer_pkg::*;

    localparam int RST_C = 8;
    localparam int TO_C  = 100;
    localparam int DEB_C = 4;
    localparam int MR_C  = 2;
    localparam int BO_C  = 10;
    localparam int NCYC  = 20000;

    logic        axi_clk = 1'b0;
    logic        rst, enable, restart;
    logic [3:0]  gth_status;
    logic        gth_rst, link_up, failed;
    logic [2:0]  state, retry_cnt;
    logic [15:0] drop_cnt;

    always #2 axi_clk = ~axi_clk;

    gth_link_sequencer #(
        .RST_CYCLES(RST_C), .TIMEOUT_CYCLES(TO_C), .DEBOUNCE(DEB_C),
        .MAX_RETRY(MR_C), .BACKOFF_CYCLES(BO_C)
    ) dut (
        .axi_clk(axi_clk), .rst(rst), .enable(enable), .restart(restart),
        .gth_status(gth_status), .gth_rst(gth_rst), .link_up(link_up),
        .failed(failed), .state(state), .retry_cnt(retry_cnt), .drop_cnt(drop_cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: state plus the cycle it was entered; limits are dwell times.
    int         cyc = 0;
    int         m_st = 0, m_entry = 0, m_low = 0, m_ret = 0, m_drop = 0;
    logic [3:0] sp0 = '0, sp1 = '0;

    function automatic logic [3:0] need(input int st);
        case (st)
            2:       return 4'h1;
            3:       return 4'h3;
            4:       return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    task automatic go(input int n);
        m_st    = n;
        m_entry = cyc + 1;
        m_low   = 0;
    endtask

    task automatic mdl_step(input logic r, input logic en, input logic rs, input logic [3:0] st_in);
        logic [3:0] s;
        int         dwell;
        logic       fail;
        s     = sp1;
        sp1   = sp0;
        sp0   = st_in;
        dwell = cyc - m_entry + 1;
        fail  = 1'b0;
        if (r) begin
            go(0);
            m_ret  = 0;
            m_drop = 0;
            sp0    = '0;
            sp1    = '0;
        end else if (!en) begin
            go(0);
        end else if (rs) begin
            go(1);
            m_ret = 0;
        end else begin
            case (m_st)
                0: begin go(1); m_ret = 0; end
                1: if (dwell == RST_C) go(2);
                2, 3, 4: begin
                    if ((s & need(m_st)) == need(m_st)) go(m_st + 1);
                    else if ((s & need(m_st - 1)) != need(m_st - 1) || dwell == TO_C) fail = 1'b1;
                end
                5: begin
                    if (s != 4'hF) begin
                        m_low++;
                        if (m_low == DEB_C) begin
                            m_drop = (m_drop == 16'hFFFF) ? m_drop : m_drop + 1;
                            m_ret  = 0;
                            go(6);
                        end
                    end else begin
                        m_low = 0;
                    end
                end
                6: if (dwell == BO_C) go(1);
                default: ;
            endcase
            if (fail) begin
                if (m_ret < MR_C) begin m_ret++; go(6); end
                else go(7);
            end
        end
    endtask

    // Link environment: each attempt picks a behaviour, status follows time since gth_rst fell.
    int mode = 0, d1 = 0, d2 = 0, d3 = 0, since = 0, gl = 0, glbit = 0, en_low = 0;
    int n_up = 0, n_failed = 0, n_drop_seen = 0;

    initial begin
        logic [3:0] sv;
        rst = 1'b1; enable = 1'b0; restart = 1'b0; gth_status = '0;
        for (int i = 0; i < NCYC; i++) begin
            @(negedge axi_clk);
            cyc++;
            if (m_st == 1) begin
                mode = $urandom_range(0, 9);
                d1   = $urandom_range(0, 20);
                d2   = d1 + $urandom_range(0, 20);
                d3   = (mode >= 8) ? d2 + $urandom_range(TO_C - 6, TO_C + 6)
                                   : d2 + $urandom_range(0, 20);
            end
            since = (m_st inside {2, 3, 4, 5}) ? since + 1 : 0;
            sv = '0;
            if (mode <= 4 || mode >= 8) begin
                sv[GS_PLL]    = (since >= d1);
                sv[GS_TXDONE] = (since >= d2);
                sv[GS_RXDONE] = (since >= d3);
                sv[GS_CDR]    = (since >= d3);
            end else if (mode == 7) begin
                sv[GS_PLL]    = (since >= d1) && (since < d2 + 6);
                sv[GS_TXDONE] = (since >= d2);
            end
            if (m_st == 5) begin
                if (gl == 0 && $urandom_range(0, 29) == 0) begin
                    gl    = $urandom_range(1, 6);
                    glbit = $urandom_range(0, 3);
                end
                if (gl > 0) begin sv[glbit] = 1'b0; gl--; end
            end else begin
                gl = 0;
            end
            gth_status = sv;

            rst = (i < 3) || ($urandom_range(0, 2999) == 0) ||
                  (m_st == 4 && $urandom_range(0, 199) == 0);
            if (en_low > 0) en_low--;
            else if (i > 5 && $urandom_range(0, 599) == 0) en_low = $urandom_range(1, 5);
            enable  = (en_low == 0);
            restart = ($urandom_range(0, 399) == 0) ||
                      (en_low > 0 && $urandom_range(0, 2) == 0) ||
                      (m_st inside {2, 3, 4} && (cyc - m_entry + 1) == TO_C &&
                       $urandom_range(0, 3) == 0);

            mdl_step(rst, enable, restart, gth_status);

            @(posedge axi_clk);
            #1;
            chk("state",     32'(state),     32'(m_st));
            chk("gth_rst",   32'(gth_rst),   32'(!(m_st inside {2, 3, 4, 5})));
            chk("link_up",   32'(link_up),   32'(m_st == 5));
            chk("failed",    32'(failed),    32'(m_st == 7));
            chk("retry_cnt", 32'(retry_cnt), 32'(m_ret));
            chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
            if (m_st == 5) n_up++;
            if (m_st == 7) n_failed++;
            if (m_drop > 0) n_drop_seen++;
        end
        $display("coverage: up_cycles=%0d failed_cycles=%0d drop_cycles=%0d", n_up, n_failed, n_drop_seen);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
